// File: rtl/float_cmp.sv
// Pipelined IEEE-754 compare: classify and magnitude-compare operands, then
// resolve the selected predicate. All stages hold together on output backpressure.
module float_cmp #(
  parameter int EXP_W   = 11,
  parameter int MAN_W   = 52,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [2:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   z,
  output logic                   unord,
  output logic [15:0]            nan_count
);

  localparam int M = EXP_W + MAN_W;

  // Handshake: a stage moves only while the output is not blocked
  // (stall = out_valid & ~out_ready); in_ready is the inverse of stall.
  typedef struct packed {
    logic [2:0] op;
    logic       sa;
    logic       sb;
    logic       both_zero;
    logic       mag_lt;
    logic       mag_eq;
    logic       unord;
  } feat_t;

  logic        stall;
  logic        accept;
  logic        nan_a, nan_b;
  feat_t       feat_in;
  logic        res_v, res_z, res_u;
  logic [15:0] nan_count_q, nan_count_d;

  assign stall     = res_v & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = res_v;
  assign z         = res_z;
  assign unord     = res_u;
  assign nan_count = nan_count_q;

  assign nan_a = (&a[M-1:MAN_W]) & (|a[MAN_W-1:0]);
  assign nan_b = (&b[M-1:MAN_W]) & (|b[MAN_W-1:0]);

  // The single magnitude compare of the whole pipeline lives here.
  always_comb begin
    feat_in           = '0;
    feat_in.op        = op;
    feat_in.sa        = a[M];
    feat_in.sb        = b[M];
    feat_in.both_zero = ~(|a[M-1:0]) & ~(|b[M-1:0]);
    feat_in.mag_lt    = a[M-1:0] < b[M-1:0];
    feat_in.mag_eq    = a[M-1:0] == b[M-1:0];
    feat_in.unord     = nan_a | nan_b;
  end

  // Returns {z, unord}; a magnitude order is inverted when both operands are negative.
  function automatic logic [1:0] resolve(input feat_t f);
    logic eq, lt, gt, r;
    eq = f.both_zero | ((f.sa == f.sb) & f.mag_eq);
    if (f.both_zero)     lt = 1'b0;
    else if (f.sa != f.sb) lt = f.sa;
    else if (!f.sa)      lt = f.mag_lt;
    else                 lt = ~f.mag_lt & ~f.mag_eq;
    gt = ~eq & ~lt;
    case (f.op)
      3'b000:  r = ~f.unord & eq;
      3'b001:  r = f.unord | ~eq;
      3'b010:  r = ~f.unord & lt;
      3'b011:  r = ~f.unord & (lt | eq);
      3'b100:  r = ~f.unord & gt;
      3'b101:  r = ~f.unord & (gt | eq);
      3'b110:  r = f.unord;
      default: r = ~f.unord;
    endcase
    return {r, f.unord};
  endfunction

  generate
    if (LATENCY == 1) begin : g_single
      logic v_q, z_q, u_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
          u_q <= 1'b0;
        end else if (!stall) begin
          v_q        <= in_valid;
          {z_q, u_q} <= resolve(feat_in);
        end
      end
      assign res_v = v_q;
      assign res_z = z_q;
      assign res_u = u_q;
    end else begin : g_multi
      feat_t               feat_q;
      logic                feat_v_q;
      logic [LATENCY-2:0]  v_q, z_q, u_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          feat_q   <= '0;
          feat_v_q <= 1'b0;
          v_q      <= '0;
          z_q      <= '0;
          u_q      <= '0;
        end else if (!stall) begin
          feat_q             <= feat_in;
          feat_v_q           <= in_valid;
          v_q[0]             <= feat_v_q;
          {z_q[0], u_q[0]}   <= resolve(feat_q);
          for (int i = 1; i < LATENCY - 1; i++) begin
            v_q[i] <= v_q[i-1];
            z_q[i] <= z_q[i-1];
            u_q[i] <= u_q[i-1];
          end
        end
      end
      assign res_v = v_q[LATENCY-2];
      assign res_z = z_q[LATENCY-2];
      assign res_u = u_q[LATENCY-2];
    end
  endgenerate

  // NaN transactions are counted as they are accepted, saturating at all-ones.
  always_comb begin
    nan_count_d = nan_count_q;
    if (accept && feat_in.unord && (nan_count_q != 16'hFFFF))
      nan_count_d = nan_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nan_count_q <= 16'd0;
    else     nan_count_q <= nan_count_d;
  end

endmodule

// File: tb/tb_float_cmp.sv
// Bench for float_cmp: directed vectors with literal expectations, plus a
// real-arithmetic reference model checked against the outputs every cycle.
module tb_float_cmp;

  localparam int EXP_W   = 11;
  localparam int MAN_W   = 52;
  localparam int LATENCY = 2;

  localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2, LE = 3'd3;
  localparam logic [2:0] GT = 3'd4, GE = 3'd5, UO = 3'd6, ORD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        z;
  logic        unord;
  logic [15:0] nan_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt = 0;
  int consumed = 0;
  bit head_seen = 0;
  bit mix_done  = 0;
  logic [15:0] nan_exp = '0;
  logic [1:0]  mr;

  logic [1:0] exp_q[$];
  int         cyc_q[$];
  int         stl_q[$];

  logic [63:0] vals [0:13] = '{
    64'h0000000000000000, 64'h8000000000000000, 64'h3FF0000000000000,
    64'hBFF0000000000000, 64'h4000000000000000, 64'hC000000000000000,
    64'h0000000000000001, 64'h0000000000000002, 64'h8000000000000001,
    64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000,
    64'h7FEFFFFFFFFFFFFF, 64'hFFF0000000000001
  };

  float_cmp #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .unord(unord), .nan_count(nan_count)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: NaN by field definition, ordering by real arithmetic.
  function automatic logic [1:0] model(input logic [63:0] x, input logic [63:0] y,
                                       input logic [2:0] o);
    logic nx, ny, u, r;
    real  rx, ry;
    nx = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    ny = (y[62:52] == 11'h7FF) && (y[51:0] != 52'd0);
    u  = nx | ny;
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    if (u) r = (o == NE) || (o == UO);
    else begin
      case (o)
        EQ:      r = (rx == ry);
        NE:      r = (rx != ry);
        LT:      r = (rx <  ry);
        LE:      r = (rx <= ry);
        GT:      r = (rx >  ry);
        GE:      r = (rx >= ry);
        UO:      r = 1'b0;
        default: r = 1'b1;
      endcase
    end
    return {r, u};
  endfunction

  // Scoreboard / compare process
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      stl_q.delete();
      nan_exp   = '0;
      head_seen = 0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("nan_count", nan_count, nan_exp);
      if (exp_q.size() == 0) chk("no_stale", out_valid, 0);
      else if (out_valid) begin
        chk("z", z, exp_q[0][1]);
        chk("unord", unord, exp_q[0][0]);
        if (!head_seen) chk("latency", cyc - cyc_q[0], LATENCY + stall_cnt - stl_q[0]);
        head_seen = 1;
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(cyc_q.pop_front());
          void'(stl_q.pop_front());
          head_seen = 0;
          consumed++;
        end
      end
      if (in_valid && in_ready) begin
        mr = model(a, b, op);
        exp_q.push_back(mr);
        cyc_q.push_back(cyc);
        stl_q.push_back(stall_cnt);
        if (mr[0] && nan_exp != 16'hFFFF) nan_exp = nan_exp + 16'd1;
      end
      if (out_valid && !out_ready) stall_cnt++;
    end
  end

  // Drivers: all inputs change at posedge+1; tasks return at posedge+1.
  task automatic send(input logic [63:0] ta, input logic [63:0] tb_v, input logic [2:0] top);
    bit done = 0;
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    @(posedge clk); #1;
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    op = 3'($urandom_range(0, 7));
  endtask

  task automatic expect_res(input string nm, input logic ez, input logic eu);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk({nm, "_valid"}, seen, 1);
    if (seen) begin
      chk({nm, "_z"}, z, ez);
      chk({nm, "_unord"}, unord, eu);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int cons0;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_z", z, 0);
    chk("rst_unord", unord, 0);
    chk("rst_nan_count", nan_count, 0);
    rst = 1'b0;

    send(64'h4000000000000000, 64'h3FF0000000000000, GT); expect_res("gt_2_1", 1, 0);
    send(64'h3FF0000000000000, 64'h4000000000000000, GT); expect_res("gt_1_2", 0, 0);
    send(64'h8000000000000000, 64'h0000000000000000, EQ); expect_res("eq_zeros", 1, 0);
    send(64'h8000000000000000, 64'h0000000000000000, LT); expect_res("lt_zeros", 0, 0);
    chk("nan_count_0", nan_count, 0);
    send(64'h7FF8000000000000, 64'h3FF0000000000000, EQ); expect_res("nan_eq", 0, 1);
    send(64'h7FF8000000000000, 64'h3FF0000000000000, NE); expect_res("nan_ne", 1, 1);
    send(64'h7FF8000000000000, 64'h3FF0000000000000, GT); expect_res("nan_gt", 0, 1);
    send(64'h7FF8000000000000, 64'h3FF0000000000000, UO); expect_res("nan_unord", 1, 1);
    chk("nan_count_4", nan_count, 4);
    send(64'h0000000000000001, 64'h0000000000000002, LT); expect_res("lt_subnorm", 1, 0);
    send(64'hFFF0000000000000, 64'hBFF0000000000000, LT); expect_res("lt_neginf", 1, 0);
    send(64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, GT); expect_res("gt_inf_max", 1, 0);
    send(64'h3FF0000000000000, 64'h3FF0000000000000, LE); expect_res("le_equal", 1, 0);
    send(64'hC000000000000000, 64'hBFF0000000000000, GE); expect_res("ge_neg", 0, 0);
    send(64'h3FF0000000000000, 64'h4000000000000000, ORD); expect_res("ord_num", 1, 0);
    send(64'h7FF0000000000000, 64'h7FF0000000000000, NE); expect_res("ne_inf", 0, 0);

    // Back-to-back stream with a three-cycle output stall in the middle
    cons0 = consumed;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vals[i], vals[(i + 3) % 14], 3'(i));
      end
      begin
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_stall", in_ready, 0);
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_delivered", consumed - cons0, 6);

    // Mixed table vectors under random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(vals[$urandom_range(0, 13)], vals[$urandom_range(0, 13)], 3'($urandom_range(0, 7)));
        mix_done = 1;
      end
      begin
        while (!mix_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two results in flight
    send(64'h7FF8000000000000, 64'h3FF0000000000000, EQ);
    send(64'h7FF8000000000000, 64'h3FF0000000000000, NE);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_nan_count", nan_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_z", z, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    send(64'h4000000000000000, 64'h3FF0000000000000, GE); expect_res("post_rst_ge", 1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
